note_tone_gen: RTL and testbench

Downstream stage of the song sequencers. Takes the 5-bit note code they emit on their beat clock and drives the piano speaker pin with a square wave at the matching pitch, or holds it silent on a rest. The note code crosses into the system clock domain through a stability filter. Pitch changes are glitch-free: no speaker level ever lasts less than a full half-period.

---
 rtl/tone_pkg.sv | 45 ++++
 rtl/note_sync.sv | 29 ++
 rtl/note_tone_gen.sv | 130 +++++++++++++
 tb/tb_note_tone_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared definitions for the note tone generator: note codes, equal-tempered
// frequency table, half-period helper and FSM state type.
package tone_pkg;

    localparam logic [4:0] NOTE_SILENT = 5'd0;
    localparam logic [4:0] NOTE_C4     = 5'd1;
    localparam logic [4:0] NOTE_C5     = 5'd8;
    localparam logic [4:0] NOTE_C6     = 5'd15;
    localparam logic [4:0] NOTE_A6     = 5'd20;
    localparam logic [4:0] NOTE_REST   = 5'd21;

    localparam int NUM_TONES = 20;

    // Frequencies in milli-hertz, equal temperament anchored at C4 = 261.63 Hz.
    localparam longint unsigned FREQ_MHZ [NUM_TONES] = '{
        64'd261630,  64'd293670,  64'd329626,  64'd349234,
        64'd392000,  64'd440008,  64'd493892,
        64'd523260,  64'd587340,  64'd659252,  64'd698468,
        64'd784000,  64'd880015,  64'd987784,
        64'd1046520, 64'd1174680, 64'd1318504, 64'd1396936,
        64'd1568000, 64'd1760030
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } tone_state_t;

    function automatic logic is_rest(input logic [4:0] code);
        return (code == NOTE_SILENT) || (code > NOTE_A6);
    endfunction

    // Rounded clock cycles per half period; 0 for rest codes.
    function automatic longint unsigned half_period(input logic [4:0] code,
                                                    input longint unsigned clk_hz);
        logic [4:0]      idx;
        longint unsigned f;
        if (is_rest(code)) return 64'd0;
        idx = code - 5'd1;
        f   = FREQ_MHZ[idx];
        return (clk_hz * 64'd1000 + f) / (64'd2 * f);
    endfunction

endpackage

// File: rtl/note_sync.sv
// Three-flop synchronizer for the sequencer note code plus a stability
// filter: note_q only takes a code seen on two consecutive cycles.
module note_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] note_code,
    output logic [4:0] note_q
);

    logic [4:0] sync1;
    logic [4:0] sync2;
    logic [4:0] sync3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            sync3  <= '0;
            note_q <= '0;
        end else begin
            sync1 <= note_code;
            sync2 <= sync1;
            sync3 <= sync2;
            if ((sync2 == sync3) && (sync2 != note_q))
                note_q <= sync2;
        end
    end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave speaker driver for sequencer note codes; pitch changes only at
// half-period boundaries. Define NOTE_ARTIC_EN to insert a silent gap between notes.
//
// state   | meaning
// IDLE    | silent, waiting for a non-rest note
// PLAY    | toggling spk every HALF_active cycles
// GAP     | articulation silence between two notes (NOTE_ARTIC_EN only)
module note_tone_gen
    import tone_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int ARTIC_CYC = CLK_HZ / 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] note_code,
    output logic       spk,
    output logic       playing,
    output logic [4:0] cur_note
);

    localparam longint unsigned HALF_MAX = half_period(NOTE_C4, 64'(CLK_HZ));
    localparam int HW = $clog2(HALF_MAX + 64'd1);
    localparam int GW = $clog2(ARTIC_CYC + 1);
    localparam int CW = (HW > GW) ? HW : GW;

    logic [4:0]    note_q;
    tone_state_t   state;
    logic [CW-1:0] cnt;
    logic [HW-1:0] half_act;
    logic [HW-1:0] half_new;
    logic          at_bound;
    logic [HW-1:0] half_rom [32];

    note_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .note_code (note_code),
        .note_q    (note_q)
    );

    // Half-period lookup built at elaboration, one entry per code.
    for (genvar i = 0; i < 32; i++) begin : g_rom
        assign half_rom[i] = HW'(half_period(5'(i), 64'(CLK_HZ)));
    end

    assign half_new = half_rom[note_q];
    assign at_bound = (cnt == CW'(half_act - HW'(1)));
    assign playing  = (state != ST_IDLE);
    assign cur_note = note_q;

`ifdef NOTE_ARTIC_EN
    logic [4:0] act_note;
    logic       gap_end;

    assign gap_end = (cnt == CW'(ARTIC_CYC - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            spk      <= 1'b0;
            half_act <= '0;
`ifdef NOTE_ARTIC_EN
            act_note <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    spk <= 1'b0;
                    if (!is_rest(note_q)) begin
                        state    <= ST_PLAY;
                        spk      <= 1'b1;
                        half_act <= half_new;
`ifdef NOTE_ARTIC_EN
                        act_note <= note_q;
`endif
                    end
                end
                ST_PLAY: begin
                    if (at_bound) begin
                        cnt <= '0;
                        // A rest always lands low and idle, whichever half just ended.
                        if (is_rest(note_q)) begin
                            state <= ST_IDLE;
                            spk   <= 1'b0;
                        end
`ifdef NOTE_ARTIC_EN
                        else if (note_q != act_note) begin
                            state <= ST_GAP;
                            spk   <= 1'b0;
                        end
`endif
                        else begin
                            spk      <= ~spk;
                            half_act <= half_new;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef NOTE_ARTIC_EN
                ST_GAP: begin
                    if (gap_end) begin
                        cnt <= '0;
                        if (is_rest(note_q)) begin
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_PLAY;
                            spk      <= 1'b1;
                            half_act <= half_new;
                            act_note <= note_q;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    spk   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: measures speaker level lengths against half periods
// computed from equal-temperament arithmetic.
module tb_note_tone_gen;

    localparam int CLK_HZ = 1_000_000;
    localparam int ARTIC  = 50;
    localparam int BOUND  = 4000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] note_code = 5'd0;
    logic       spk;
    logic       playing;
    logic [4:0] cur_note;

    int         vectors = 0;
    int         errs = 0;
    logic [4:0] cur_code = 5'd0;

    note_tone_gen #(.CLK_HZ(CLK_HZ), .ARTIC_CYC(ARTIC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .note_code (note_code),
        .spk       (spk),
        .playing   (playing),
        .cur_note  (cur_note)
    );

    always #5 clk = ~clk;

    function automatic int ref_half(input logic [4:0] code);
        int  scale [7];
        int  semi;
        real f;
        scale = '{0, 2, 4, 5, 7, 9, 11};
        if (code == 5'd0 || code > 5'd20) return 0;
        semi = ((int'(code) - 1) / 7) * 12 + scale[(int'(code) - 1) % 7];
        f    = 261.63 * (2.0 ** (real'(semi) / 12.0));
        return $rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at the first negedge sample of a level; returns its length in cycles.
    task automatic measure(output int len, input int chg_at, input logic [4:0] chg_code,
                           input bit glitch);
        logic lvl;
        lvl = spk;
        len = 0;
        while (spk === lvl && len < BOUND) begin
            if (len == chg_at) note_code = chg_code;
            if (glitch && len == chg_at + 1) note_code = cur_code;
            len++;
            @(negedge clk);
        end
    endtask

    task automatic count_to_rise(output int n);
        n = 0;
        while (spk !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Change the note part-way into the current level and check the next three levels.
    task automatic do_change(input logic [4:0] nc, input int off);
        int   l0, l1, l2, oh, nh, e0, e1, e2;
        logic hi;
        hi = spk;
        oh = ref_half(cur_code);
        nh = ref_half(nc);
        e0 = oh;
        e1 = nh;
        e2 = nh;
`ifdef NOTE_ARTIC_EN
        if (nc != cur_code) begin
            if (hi) e1 = ARTIC;
            else    e0 = oh + ARTIC;
        end
`endif
        measure(l0, off, nc, 1'b0);
        check("chg_playing", 32'(playing), 32'd1);
        measure(l1, -1, 5'd0, 1'b0);
        measure(l2, -1, 5'd0, 1'b0);
        check("chg_lvl0", l0, e0);
        check("chg_lvl1", l1, e1);
        check("chg_lvl2", l2, e2);
        cur_code = nc;
    endtask

    initial begin
        int         len;
        int         n;
        int         quiet_bad;
        int         off;
        logic [4:0] pool [7];
        logic [4:0] nc;

        pool = '{5'd3, 5'd8, 5'd9, 5'd10, 5'd12, 5'd14, 5'd15};

        rst_n = 1'b0;
        note_code = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_spk", 32'(spk), 32'd0);
        check("rst_playing", 32'(playing), 32'd0);
        check("rst_cur_note", 32'(cur_note), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        note_code = 5'd8;
        repeat (4) @(negedge clk);
        check("edge4_cur_note", 32'(cur_note), 32'd8);
        check("edge4_spk", 32'(spk), 32'd0);
        @(negedge clk);
        check("edge5_spk", 32'(spk), 32'd1);
        check("edge5_playing", 32'(playing), 32'd1);
        cur_code = 5'd8;

        measure(len, -1, 5'd0, 1'b0);
        check("c8_high", len, ref_half(5'd8));
        measure(len, -1, 5'd0, 1'b0);
        check("c8_low", len, ref_half(5'd8));

        measure(len, 200, 5'd9, 1'b1);
        check("glitch_lvl", len, ref_half(5'd8));
        measure(len, -1, 5'd0, 1'b0);
        check("glitch_next", len, ref_half(5'd8));
        check("glitch_cur_note", 32'(cur_note), 32'd8);

        do_change(5'd12, 300);

        repeat (150) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_spk", 32'(spk), 32'd0);
        check("async_rst_playing", 32'(playing), 32'd0);
        check("async_rst_cur_note", 32'(cur_note), 32'd0);
        note_code = 5'd8;
        @(negedge clk);
        rst_n = 1'b1;
        count_to_rise(n);
        check("restart_edges", n, 5);
        check("restart_cur_note", 32'(cur_note), 32'd8);
        check("restart_playing", 32'(playing), 32'd1);
        cur_code = 5'd8;

        do_change(5'd9, 100);

        for (int i = 0; i < 6; i++) begin
            nc  = pool[$urandom_range(0, 6)];
            off = $urandom_range(0, ref_half(cur_code) - 10);
            do_change(nc, off);
        end

        do_change(5'd1, 100);
        if (spk !== 1'b1) begin
            measure(len, -1, 5'd0, 1'b0);
            check("c1_low", len, ref_half(5'd1));
        end
        measure(len, 100, 5'd21, 1'b0);
        check("rest_high_len", len, ref_half(5'd1));
        check("rest_spk", 32'(spk), 32'd0);
        check("rest_playing", 32'(playing), 32'd0);
        check("rest_cur_note", 32'(cur_note), 32'd21);
        quiet_bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (spk !== 1'b0 || playing !== 1'b0) quiet_bad++;
        end
        check("rest_quiet", quiet_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
